// File: rtl/ifu.sv
// Instruction fetch unit: issues PC-tagged fetches to imem and buffers returned words for decode.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module ifu #(
  parameter logic [`ISA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [`ISA_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [`ISA_WIDTH-1:0] resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [`ISA_WIDTH-1:0] inst,
  output logic [`ISA_WIDTH-1:0] pc,
  input  logic                  redirect_valid,
  input  logic [`ISA_WIDTH-1:0] redirect_pc,
`ifdef IFU_PERF_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high; valid never
  // depends on ready. resp_valid has no ready and is always taken (credit keeps the buffer safe).

  localparam int W  = `ISA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            run_en_q;

  logic [W-1:0]    tag_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [W-1:0]    fifo_pc_q   [FIFO_DEPTH];
  logic [W-1:0]    fifo_inst_q [FIFO_DEPTH];
  logic [AW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic            req_fire, resp_run, enq, deq;
  logic [CW:0]     credit_use;
  logic [CW-1:0]   remain;

  assign credit_use = {1'b0, out_q} + {1'b0, fifo_cnt_q};
  assign req_valid  = run_en_q && (state_q == RUN) && !redirect_valid && (credit_use < DEPTH_C);
  assign req_addr   = fetch_pc_q;
  assign req_fire   = req_valid && req_ready;

  // A response with nothing outstanding is illegal and simply ignored.
  assign resp_run   = resp_valid && (state_q == RUN) && (out_q != '0);
  assign enq        = resp_run && !redirect_valid;
  assign deq        = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (fifo_cnt_q != '0);
  assign inst       = fifo_inst_q[fifo_rd_q];
  assign pc         = fifo_pc_q[fifo_rd_q];
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    remain     = out_q - CW'(resp_run);

    if (req_fire) begin
      tag_wr_d   = tag_wr_q + AW'(1);
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp_run) tag_rd_d = tag_rd_q + AW'(1);
    case ({req_fire, resp_run})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase

    if (enq) fifo_wr_d = fifo_wr_q + AW'(1);
    if (deq) fifo_rd_d = fifo_rd_q + AW'(1);
    case ({enq, deq})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (state_q == FLUSH) begin
      if (resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (drop_d == '0) state_d = RUN;
    end

    // Redirect wins over everything: both queues empty, stale responses become drops.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      out_d      = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      if (state_q == RUN) begin
        drop_d  = remain;
        state_d = (remain != '0) ? FLUSH : RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      run_en_q   <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem_q[i]   <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      run_en_q   <= 1'b1;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
      if (enq) begin
        fifo_pc_q[fifo_wr_q]   <= tag_mem_q[tag_rd_q];
        fifo_inst_q[fifo_wr_q] <= resp_data;
      end
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (deq) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (!inst_valid && (state_q == RUN)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: in-order imem model with selectable latency and a pc/inst scoreboard.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dbg_state;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  ifu #(.RESET_PC(32'h8000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] exp_q[$];
  logic [31:0] seen_addr[$];
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  logic [31:0] exp_fetch = 32'h8000_0000;
  int          lat = 1;
  int          req_cnt = 0;
  int          deq_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // imem model + monitor: evaluated mid-cycle for the upcoming posedge
  always @(negedge clk) begin
    if (!rst) begin
      pend_due.delete();
      pend_addr.delete();
      exp_q.delete();
      exp_fetch = 32'h8000_0000;
      resp_valid = 1'b0;
      resp_data  = '0;
    end else begin
      if (pend_due.size() != 0 && pend_due[0] == cyc + 1) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        resp_valid = 1'b0;
        resp_data  = 32'hDEAD_BEEF;
      end
      if (redirect_valid) begin
        check("req_gated_by_redirect", req_valid, 0);
        exp_q.delete();
        exp_fetch = redirect_pc;
      end else begin
        if (req_valid && req_ready) begin
          check("req_addr", req_addr, exp_fetch);
          seen_addr.push_back(req_addr);
          pend_due.push_back(cyc + 1 + lat);
          pend_addr.push_back(req_addr);
          exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
          exp_fetch = exp_fetch + 32'd4;
          req_cnt++;
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            check("deq_unexpected", inst_valid, 0);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("deq_pc", pc, e[63:32]);
            check("deq_inst", inst, e[31:0]);
            deq_cnt++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic drain();
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pend_due.size() == 0 && exp_q.size() == 0) break;
      tick(1);
    end
    check("drain_done", (pend_due.size() == 0 && exp_q.size() == 0), 1);
  endtask

  task automatic wait_inst(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) break;
      tick(1);
    end
    check(tag, inst_valid, 1);
  endtask

  initial begin
    rst = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(3);
    check("rst_req_valid", req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", pc, 0);
    check("rst_state", dbg_state, 0);

    // streaming, 1-cycle imem
    rst = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
    tick(1);
    check("first_req_valid", req_valid, 1);
    tick(20);
    check("stream_addr0", seen_addr[0], 32'h8000_0000);
    check("stream_addr1", seen_addr[1], 32'h8000_0004);
    check("stream_addr2", seen_addr[2], 32'h8000_0008);
    check("stream_progress", deq_cnt >= 10, 1);

    // decode stall: credit limit holds, nothing lost
    inst_ready = 1'b0;
    req_cnt = 0;
    tick(10);
    check("stall_req_cnt_le_depth", req_cnt <= 2, 1);
    check("stall_req_valid", req_valid, 0);
    check("stall_inst_valid", inst_valid, 1);
    check("stall_buffered", exp_q.size(), 2);
    inst_ready = 1'b1;
    tick(5);

    // redirect with two responses in flight (3-cycle imem)
    drain();
    lat = 3; req_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (pend_due.size() == 2 && pend_due[0] > cyc + 1) break;
      tick(1);
    end
    check("two_in_flight", pend_due.size(), 2);
    redirect(32'h8000_0100);
    check("flush_state", dbg_state, 1);
    check("flush_inst_valid", inst_valid, 0);
    check("flush_req_valid", req_valid, 0);
    wait_inst("redirect_inst_timeout");
    check("redirect_first_pc", pc, 32'h8000_0100);

    // redirect colliding with a response and a decode handshake
    drain();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (inst_valid && pend_due.size() != 0 && pend_due[0] == cyc + 1) break;
      tick(1);
    end
    check("collide_setup", inst_valid, 1);
    redirect(32'h8000_0200);
    check("collide_inst_valid", inst_valid, 0);
    check("collide_state", dbg_state, 0);
    wait_inst("collide_inst_timeout");
    check("collide_first_pc", pc, 32'h8000_0200);

    // misaligned target loaded as-is
    drain();
    seen_addr.delete();
    redirect(32'h8000_0402);
    req_ready = 1'b1;
    tick(6);
    check("misaligned_addr0", seen_addr[0], 32'h8000_0402);
    check("misaligned_addr1", seen_addr[1], 32'h8000_0406);

    // 32-bit wrap of fetch pc
    drain();
    seen_addr.delete();
    redirect(32'hFFFF_FFF8);
    req_ready = 1'b1;
    tick(8);
    check("wrap_count", seen_addr.size() >= 3, 1);
    check("wrap_addr0", seen_addr[0], 32'hFFFF_FFF8);
    check("wrap_addr1", seen_addr[1], 32'hFFFF_FFFC);
    check("wrap_addr2", seen_addr[2], 32'h0000_0000);

    // reset mid-operation
    tick(3);
    rst = 1'b0;
    tick(2);
    check("midrst_req_valid", req_valid, 0);
    check("midrst_inst_valid", inst_valid, 0);
    check("midrst_inst", inst, 0);
    check("midrst_pc", pc, 0);
    check("midrst_state", dbg_state, 0);
    seen_addr.delete();
    rst = 1'b1;
    tick(5);
    check("midrst_addr0", seen_addr[0], 32'h8000_0000);

    // random req_ready / inst_ready, 3-cycle imem
    drain();
    lat = 3;
    deq_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      req_ready  = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    check("random_progress", deq_cnt > 5, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
